// File: rtl/hilo_muldiv.sv
// hilo_muldiv: multi-cycle multiply/divide unit owning the HI and LO registers.
// Executes MULT, MULTU, DIV, DIVU (32 RUN cycles + 1 FIX cycle) and MTHI/MTLO
// (single-cycle writes). All outputs are registered.
//
// Ports:
//   clk       in   1   clock, all state changes on the rising edge
//   rst_n     in   1   synchronous active-low reset
//   start     in   1   issue strobe for a HI/LO-writing instruction
//   funct     in   6   R-type funct field selecting the operation
//   rs_data   in  32   multiplicand / dividend / MTHI-MTLO source
//   rt_data   in  32   multiplier / divisor
//   hi        out 32   HI register
//   lo        out 32   LO register
//   busy      out  1   high while a multiply or divide is in flight
//   done      out  1   one-cycle pulse when new HI/LO become visible
//   div_zero  out  1   one-cycle pulse with done when a divide had divisor 0

module hilo_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic        is_div_q;
  logic        neg_res_q;   // negate product / quotient in FIX
  logic        neg_rem_q;   // negate remainder in FIX
  logic        dz_q;        // divide with divisor 0: suppress the commit
  logic [31:0] opb_q;       // multiplicand or divisor magnitude
  // Multiply: running product {upper accumulator, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting out / quotient in}.
  logic [63:0] work_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;
  logic        div_zero_q;

  logic        is_muldiv_s;
  logic        is_signed_s;
  logic        is_div_op_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic [32:0] mul_add_s;
  logic [63:0] mul_d;
  logic [32:0] rem_sh_s;
  logic [32:0] rem_diff_s;
  logic [63:0] div_d;
  logic [63:0] prod_neg_s;
  logic [31:0] quo_fix_s;
  logic [31:0] rem_fix_s;

  // Decode, operand magnitudes and one iteration step of each algorithm.
  always_comb begin
    is_muldiv_s = (funct == FN_MULT) || (funct == FN_MULTU) ||
                  (funct == FN_DIV)  || (funct == FN_DIVU);
    is_signed_s = (funct == FN_MULT) || (funct == FN_DIV);
    is_div_op_s = (funct == FN_DIV)  || (funct == FN_DIVU);

    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    if (is_signed_s && rs_data[31]) begin
      mag_a_s = ~rs_data + 32'd1;
    end else begin
      mag_a_s = rs_data;
    end
    if (is_signed_s && rt_data[31]) begin
      mag_b_s = ~rt_data + 32'd1;
    end else begin
      mag_b_s = rt_data;
    end

    // Shift-add: add multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole accumulator right.
    if (work_q[0]) begin
      mul_add_s = {1'b0, work_q[63:32]} + {1'b0, opb_q};
    end else begin
      mul_add_s = {1'b0, work_q[63:32]};
    end
    mul_d = {mul_add_s, work_q[31:1]};

    // Restoring division: bring in the next dividend bit, subtract if it fits.
    rem_sh_s   = {work_q[63:32], work_q[31]};
    rem_diff_s = rem_sh_s - {1'b0, opb_q};
    if (rem_sh_s >= {1'b0, opb_q}) begin
      div_d = {rem_diff_s[31:0], work_q[30:0], 1'b1};
    end else begin
      div_d = {rem_sh_s[31:0], work_q[30:0], 1'b0};
    end

    prod_neg_s = ~work_q + 64'd1;
    if (neg_res_q) begin
      quo_fix_s = ~work_q[31:0] + 32'd1;
    end else begin
      quo_fix_s = work_q[31:0];
    end
    if (neg_rem_q) begin
      rem_fix_s = ~work_q[63:32] + 32'd1;
    end else begin
      rem_fix_s = work_q[63:32];
    end
  end

  // Control FSM, iteration datapath and HI/LO registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      opb_q      <= 32'd0;
      work_q     <= 64'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && (funct == FN_MTHI)) begin
            hi_q <= rs_data;
          end else if (start && (funct == FN_MTLO)) begin
            lo_q <= rs_data;
          end else if (start && is_muldiv_s) begin
            is_div_q  <= is_div_op_s;
            neg_res_q <= is_signed_s && (rs_data[31] ^ rt_data[31]);
            neg_rem_q <= is_signed_s && rs_data[31];
            dz_q      <= is_div_op_s && (rt_data == 32'd0);
            cnt_q     <= 5'd0;
            busy_q    <= 1'b1;
            state_q   <= S_RUN;
            if (is_div_op_s) begin
              opb_q  <= mag_b_s;
              work_q <= {32'd0, mag_a_s};
            end else begin
              opb_q  <= mag_a_s;
              work_q <= {32'd0, mag_b_s};
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          work_q <= is_div_q ? div_d : mul_d;
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= S_FIX;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_FIX: begin
          if (!is_div_q) begin
            {hi_q, lo_q} <= neg_res_q ? prod_neg_s : work_q;
          end else if (!dz_q) begin
            lo_q <= quo_fix_s;
            hi_q <= rem_fix_s;
          end else begin
            div_zero_q <= 1'b1;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= 5'd0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= 5'd0;
        end
      endcase
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: directed self-checking bench for hilo_muldiv.
// Drives inputs 1 time unit after the rising edge and samples there too.

module tb_hilo_muldiv;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int n_vec;
  int n_err;

  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

  hilo_muldiv dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .funct    (funct),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one multiply/divide and wait for done. Optionally pulse an MTLO
  // 'inj_at' cycles after acceptance (0 = none).
  task automatic do_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input int inj_at, input logic exp_dz);
    int lat;
    int bcnt;
    start = 1'b1; funct = f; rs_data = a; rt_data = b;
    tick();
    start = 1'b0; funct = 6'h00; rs_data = 32'h0; rt_data = 32'h0;
    chk_val({tag, "_busy_acc"}, {31'd0, busy}, 32'd1);
    lat = 0;
    bcnt = 1;
    while (!done && lat < 40) begin
      if (lat + 1 == inj_at) begin
        start = 1'b1; funct = FN_MTLO; rs_data = 32'hAAAA5555;
      end
      tick();
      start = 1'b0; funct = 6'h00; rs_data = 32'h0;
      lat++;
      if (busy) bcnt++;
    end
    chk_val({tag, "_latency"}, lat, 32'd33);
    chk_val({tag, "_busy_cycles"}, bcnt, 32'd33);
    chk_val({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    chk_val({tag, "_div_zero"}, {31'd0, div_zero}, {31'd0, exp_dz});
  endtask

  initial begin
    int dcnt;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0; start = 1'b0; funct = 6'h00; rs_data = 32'h0; rt_data = 32'h0;
    tick();
    tick();
    rst_n = 1'b1;
    chk_val("rst_hi", hi, 32'h0);
    chk_val("rst_lo", lo, 32'h0);
    chk_val("rst_flags", {29'd0, busy, done, div_zero}, 32'h0);

    // MULT -3 * 5, then done must pulse exactly once
    do_op("mult_neg", FN_MULT, 32'hFFFFFFFD, 32'd5, 0, 1'b0);
    chk_val("mult_neg_hi", hi, 32'hFFFFFFFF);
    chk_val("mult_neg_lo", lo, 32'hFFFFFFF1);
    tick();
    chk_val("done_once", {31'd0, done}, 32'd0);

    do_op("multu_ff", FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
    chk_val("multu_ff_hi", hi, 32'hFFFFFFFE);
    chk_val("multu_ff_lo", lo, 32'h00000001);
    do_op("mult_ff", FN_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
    chk_val("mult_ff_hi", hi, 32'h0);
    chk_val("mult_ff_lo", lo, 32'h1);

    do_op("div_neg", FN_DIV, 32'hFFFFFFF9, 32'd2, 0, 1'b0);
    chk_val("div_neg_lo", lo, 32'hFFFFFFFD);
    chk_val("div_neg_hi", hi, 32'hFFFFFFFF);
    do_op("divu", FN_DIVU, 32'd100, 32'd7, 0, 1'b0);
    chk_val("divu_lo", lo, 32'd14);
    chk_val("divu_hi", hi, 32'd2);
    do_op("div_ovf", FN_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
    chk_val("div_ovf_lo", lo, 32'h80000000);
    chk_val("div_ovf_hi", hi, 32'h0);

    // MTHI then divide by zero
    start = 1'b1; funct = FN_MTHI; rs_data = 32'h12345678;
    tick();
    start = 1'b0; funct = 6'h00; rs_data = 32'h0;
    chk_val("mthi_hi", hi, 32'h12345678);
    chk_val("mthi_busy", {31'd0, busy}, 32'd0);
    do_op("divz", FN_DIVU, 32'd5, 32'd0, 0, 1'b1);
    chk_val("divz_done", {31'd0, done}, 32'd1);
    chk_val("divz_hi", hi, 32'h12345678);
    chk_val("divz_lo", lo, 32'h80000000);
    tick();
    chk_val("divz_pulse_end", {31'd0, div_zero}, 32'd0);

    // Unknown funct is ignored
    start = 1'b1; funct = 6'h20; rs_data = 32'h55; rt_data = 32'h66;
    tick();
    start = 1'b0; funct = 6'h00;
    chk_val("bad_funct_busy", {31'd0, busy}, 32'd0);
    chk_val("bad_funct_lo", lo, 32'h80000000);

    // MULT -65536 * 65536 with an MTLO issued mid-run, then back-to-back DIVU
    do_op("mult_inj", FN_MULT, 32'hFFFF0000, 32'h00010000, 10, 1'b0);
    chk_val("mult_inj_hi", hi, 32'hFFFFFFFF);
    chk_val("mult_inj_lo", lo, 32'h00000000);
    do_op("divu_b2b", FN_DIVU, 32'd1000, 32'd10, 0, 1'b0);
    chk_val("divu_b2b_lo", lo, 32'd100);
    chk_val("divu_b2b_hi", hi, 32'd0);

    // Reset in the middle of a divide
    start = 1'b1; funct = FN_DIVU; rs_data = 32'd77; rt_data = 32'd3;
    tick();
    start = 1'b0; funct = 6'h00; rs_data = 32'h0; rt_data = 32'h0;
    for (int i = 0; i < 14; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_val("midrst_hi", hi, 32'h0);
    chk_val("midrst_lo", lo, 32'h0);
    chk_val("midrst_flags", {29'd0, busy, done, div_zero}, 32'h0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dcnt++;
    end
    chk_val("midrst_no_done", dcnt, 32'd0);
    do_op("mult_67", FN_MULT, 32'd6, 32'd7, 0, 1'b0);
    chk_val("mult_67_lo", lo, 32'd42);
    chk_val("mult_67_hi", hi, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
